// File: rtl/pipe_trace_buffer_pkg.sv
// rtl/pipe_trace_buffer_pkg.sv - shared encodings and helpers for the pipeline trace buffer
package pipe_trace_buffer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ARMED = 2'b01,
        ST_POST  = 2'b10,
        ST_DONE  = 2'b11
    } state_e;

    typedef enum logic [1:0] {
        TM_ADDR   = 2'b00,
        TM_IRQ    = 2'b01,
        TM_EITHER = 2'b10,
        TM_FORCE  = 2'b11
    } trig_mode_e;

    // Ceiling log2 usable in parameter expressions.
    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/pipe_trace_buffer_trace_ram.sv
// rtl/pipe_trace_buffer_trace_ram.sv - trace storage, one write port and one registered read port
module trace_ram
    import pipe_trace_buffer_pkg::*;
#(
    parameter int WIDTH = 80,
    parameter int DEPTH = 16,
    localparam int AW   = clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rdata_d;
    logic [WIDTH-1:0] rdata_q;

    // Storage array is deliberately left unreset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read data holds until the next read.
    always_comb begin
        rdata_d = rdata_q;
        if (re) begin
            rdata_d = mem[raddr];
        end
    end

    // Registered read port, cleared by reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/pipe_trace_buffer.sv
// rtl/pipe_trace_buffer.sv - triggered pipeline trace capture with post-trigger window and readout
module pipe_trace_buffer
    import pipe_trace_buffer_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16,
    parameter int NCH    = 4,
    parameter int DEPTH  = 16,
    parameter int POST   = 8,
    localparam int AW    = clog2(DEPTH),
    localparam int EW    = ADDR_W + NCH * DATA_W
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  arm,
    input  logic                  disarm,
    input  logic [1:0]            trig_mode,
    input  logic [ADDR_W-1:0]     trig_addr,
    input  logic                  force_trig,
    input  logic                  interrupt,
    input  logic                  sample_en,
    input  logic [ADDR_W-1:0]     cur_addr,
    input  logic [NCH*DATA_W-1:0] ch_data,
    input  logic                  rd_req,
    output logic [EW-1:0]         rd_data,
    output logic                  rd_valid,
    output logic                  rd_last,
    output logic [1:0]            state,
    output logic [AW-1:0]         trig_pos
);

    localparam logic [AW:0]   DEPTH_W = (AW + 1)'(DEPTH);
    localparam logic [AW:0]   POST_W  = (AW + 1)'(POST);
    localparam logic [AW:0]   ONE_W   = (AW + 1)'(1);
    localparam logic [AW-1:0] POST_A  = AW'(POST);
    localparam logic [AW-1:0] ONE_A   = AW'(1);

    state_e        state_q, state_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0]   fill_q, fill_d;
    logic [AW-1:0] post_cnt_q, post_cnt_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   remain_q, remain_d;
    logic          rd_valid_q, rd_valid_d;
    logic          rd_last_q, rd_last_d;
    logic [AW-1:0] trig_pos_q, trig_pos_d;

    logic          trig_hit;
    logic          mode_hit;
    logic          addr_hit;
    logic [AW:0]   fill_inc;
    logic          wr_en;
    logic          rd_en;
    logic          done_entry;

    // Trigger qualifier from the selected mode; force_trig works in every mode.
    always_comb begin
        addr_hit = (cur_addr == trig_addr);
        mode_hit = 1'b0;
        case (trig_mode)
            TM_ADDR:   mode_hit = addr_hit;
            TM_IRQ:    mode_hit = interrupt;
            TM_EITHER: mode_hit = addr_hit | interrupt;
            default:   mode_hit = 1'b0;
        endcase
        trig_hit = force_trig | mode_hit;
    end

    // Fill count including the sample written this cycle, saturating at DEPTH.
    assign fill_inc = (fill_q == DEPTH_W) ? fill_q : fill_q + ONE_W;

    // Capture/readout sequencing; disarm overrides everything else.
    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        fill_d     = fill_q;
        post_cnt_d = post_cnt_q;
        rd_ptr_d   = rd_ptr_q;
        remain_d   = remain_q;
        trig_pos_d = trig_pos_q;
        rd_valid_d = 1'b0;
        rd_last_d  = 1'b0;
        wr_en      = 1'b0;
        rd_en      = 1'b0;
        done_entry = 1'b0;

        if (disarm) begin
            state_d  = ST_IDLE;
            remain_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (arm) begin
                        state_d  = ST_ARMED;
                        wr_ptr_d = '0;
                        fill_d   = '0;
                    end
                end
                ST_ARMED: begin
                    if (sample_en) begin
                        wr_en    = 1'b1;
                        wr_ptr_d = wr_ptr_q + ONE_A;
                        fill_d   = fill_inc;
                        if (trig_hit) begin
                            if (POST == 0) begin
                                done_entry = 1'b1;
                            end else begin
                                state_d    = ST_POST;
                                post_cnt_d = POST_A;
                            end
                        end
                    end
                end
                ST_POST: begin
                    if (sample_en) begin
                        wr_en      = 1'b1;
                        wr_ptr_d   = wr_ptr_q + ONE_A;
                        fill_d     = fill_inc;
                        post_cnt_d = post_cnt_q - ONE_A;
                        if (post_cnt_q == ONE_A) begin
                            done_entry = 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    if (rd_last_q) begin
                        state_d = ST_IDLE;
                    end else if (rd_req && (remain_q != '0)) begin
                        rd_en      = 1'b1;
                        rd_ptr_d   = rd_ptr_q + ONE_A;
                        remain_d   = remain_q - ONE_W;
                        rd_valid_d = 1'b1;
                        rd_last_d  = (remain_q == ONE_W);
                    end
                end
                default: state_d = ST_IDLE;
            endcase

            // Oldest entry sits fill_inc slots behind the post-write pointer.
            if (done_entry) begin
                state_d    = ST_DONE;
                remain_d   = fill_inc;
                rd_ptr_d   = (wr_ptr_q + ONE_A) - fill_inc[AW-1:0];
                trig_pos_d = (fill_inc > POST_W) ? AW'(fill_inc - POST_W - ONE_W) : '0;
            end
        end
    end

    // Control state registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            wr_ptr_q   <= '0;
            fill_q     <= '0;
            post_cnt_q <= '0;
            rd_ptr_q   <= '0;
            remain_q   <= '0;
            rd_valid_q <= 1'b0;
            rd_last_q  <= 1'b0;
            trig_pos_q <= '0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            fill_q     <= fill_d;
            post_cnt_q <= post_cnt_d;
            rd_ptr_q   <= rd_ptr_d;
            remain_q   <= remain_d;
            rd_valid_q <= rd_valid_d;
            rd_last_q  <= rd_last_d;
            trig_pos_q <= trig_pos_d;
        end
    end

    trace_ram #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_trace_ram (
        .clk   (clk),
        .reset (reset),
        .we    (wr_en),
        .waddr (wr_ptr_q),
        .wdata ({cur_addr, ch_data}),
        .re    (rd_en),
        .raddr (rd_ptr_q),
        .rdata (rd_data)
    );

    assign rd_valid = rd_valid_q;
    assign rd_last  = rd_last_q;
    assign state    = state_q;
    assign trig_pos = trig_pos_q;

endmodule

// File: doc/pipe_trace_buffer.md
PIPE_TRACE_BUFFER -- requirements
Module: pipe_trace_buffer

Interface
REQ-001 Parameter DATA_W, default 16, width of each traced channel.
REQ-002 Parameter ADDR_W, default 16, width of traced instruction address.
REQ-003 Parameter NCH, default 4, number of traced data channels (1..8).
REQ-004 Parameter DEPTH, default 16, buffer entries, power of two, 4..256.
REQ-005 Parameter POST, default 8, samples captured after trigger sample, 0..DEPTH-1.
REQ-006 clk  in  1  single clock, all state on rising edge.
REQ-007 reset  in  1  asynchronous, active-low reset.
REQ-008 arm  in  1  start capture (honoured in IDLE only).
REQ-009 disarm  in  1  abort to IDLE from any state.
REQ-010 trig_mode  in  2  00 address match, 01 interrupt, 10 either, 11 force only.
REQ-011 trig_addr  in  ADDR_W  address compared against cur_addr.
REQ-012 force_trig  in  1  manual trigger, valid in every mode.
REQ-013 interrupt  in  1  core interrupt line.
REQ-014 sample_en  in  1  pipeline advance qualifier; no sample when low.
REQ-015 cur_addr  in  ADDR_W  current fetch address.
REQ-016 ch_data  in  NCH*DATA_W  packed channels, channel 0 in LSBs.
REQ-017 rd_req  in  1  pop one entry (honoured in DONE only).
REQ-018 rd_data  out  ADDR_W+NCH*DATA_W  {addr, ch_data} of popped entry.
REQ-019 rd_valid  out  1  one-cycle strobe qualifying rd_data.
REQ-020 rd_last  out  1  asserted with rd_valid on final entry.
REQ-021 state  out  2  00 IDLE, 01 ARMED, 10 POST, 11 DONE.
REQ-022 trig_pos  out  log2(DEPTH)  readout index of trigger sample, valid in DONE.

Function
REQ-023 IDLE: no writes; arm=1 -> ARMED, clears write pointer and fill count.
REQ-024 ARMED/POST: each cycle with sample_en=1 writes {cur_addr, ch_data} at write pointer, pointer increments mod DEPTH, fill count saturates at DEPTH.
REQ-025 Trigger condition evaluated only in ARMED with sample_en=1: mode 00 cur_addr==trig_addr, 01 interrupt=1, 10 either, any mode force_trig=1.
REQ-026 Trigger cycle sample is written; ARMED -> POST with post counter loaded to POST, or -> DONE directly when POST=0.
REQ-027 POST: counter decrements per written sample; sample making it zero moves state to DONE next edge.
REQ-028 Entry count for readout = fill count at DONE entry (min(samples written, DEPTH)).
REQ-029 DONE: readout oldest first; rd_req=1 -> rd_valid=1 with entry next cycle (latency 1); rd_req ignored while rd_valid high with same-cycle back-to-back allowed (one pop per cycle max).
REQ-030 rd_last=1 with final entry; state returns to IDLE the edge after rd_last.
REQ-031 trig_pos = (entry count - 1 - POST) clamped at 0.
REQ-032 disarm has priority over arm, trigger and rd_req; next edge -> IDLE, rd_valid=0.
REQ-033 arm outside IDLE, rd_req outside DONE, triggers outside ARMED: no effect.
REQ-034 Trigger on first armed sample legal: entry count 1+POST, trig_pos 0.
REQ-035 Write pointer wraps DEPTH-1 -> 0 silently; oldest entries overwritten in ARMED.

Reset
REQ-036 reset=0 forces state IDLE, pointers, counters, rd_valid, rd_last, trig_pos to 0 immediately.
REQ-037 rd_data resets to 0; buffer storage is not reset.
REQ-038 Reset mid-capture or mid-readout discards the capture; no entries readable after release.

Structure
REQ-039 Shared package holds state encoding, trig_mode encoding and clog2 helper.
REQ-040 Storage is one sub-module trace_ram: DEPTH x (ADDR_W+NCH*DATA_W), one write port, one registered read port.

Verification
REQ-041 arm, 30 samples cur_addr=0x0000..0x001D, trig_addr=0x0014 mode 00 -> DONE after sample 0x001C, 16 entries 0x000D..0x001C, trig_pos=7.
REQ-042 mode 01, interrupt on 3rd sample, POST=8 -> 11 entries, trig_pos=2, rd_last on 11th pop.
REQ-043 sample_en low alternate cycles during POST -> exactly 8 post samples, gaps not recorded.
REQ-044 disarm same cycle as trigger -> state IDLE, no DONE, rd_req produces no rd_valid.
REQ-045 reset low during readout after 5 pops -> state IDLE, rd_valid 0; re-arm captures fresh data only.
REQ-046 NCH=8, DEPTH=4, POST=0, force_trig on sample 6 -> 4 entries samples 3..6, trig_pos=3.
